// File: rtl/serial_number_pkg.sv
// Shared defaults and FSM state type for the serial number encoder.
// Optional feature macro: SERIAL_NUMBER_CHECKSUM_EN (appends one XOR checksum byte).
package serial_number_pkg;

    localparam int unsigned NUMBER_BITS_DEFAULT     = 37;
    localparam int unsigned NUMBER_BYTES_DEFAULT    = 5;
    localparam int unsigned BYTE_INDEX_BITS_DEFAULT = 3;

`ifdef SERIAL_NUMBER_CHECKSUM_EN
    localparam int unsigned CHECKSUM_BYTES = 1;
`else
    localparam int unsigned CHECKSUM_BYTES = 0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } enc_state_t;

endpackage

// File: rtl/serial_number_encoder_if.sv
// Request/status and UART TX byte handshake bundle for serial_number_encoder.
// master: the encoder side; slave: the producer of num/start and the UART TX consumer.
interface serial_number_encoder_if #(
    parameter int unsigned NUMBER_BITS = serial_number_pkg::NUMBER_BITS_DEFAULT
) ();

    logic [NUMBER_BITS-1:0] num;
    logic                   start;
    logic                   busy;
    logic                   done;
    logic [7:0]             tx_byte;
    logic                   tx_send;
    logic                   tx_ready;

    modport master (
        input  num,
        input  start,
        input  tx_ready,
        output busy,
        output done,
        output tx_byte,
        output tx_send
    );

    modport slave (
        output num,
        output start,
        output tx_ready,
        input  busy,
        input  done,
        input  tx_byte,
        input  tx_send
    );

endinterface

// File: rtl/serial_number_encoder.sv
// Serialises one signed fixed-point number into bytes (LSB first) for the UART TX.
// The top byte carries sign-extension bits above NUMBER_BITS.
// Optional feature macro: SERIAL_NUMBER_CHECKSUM_EN (extra XOR byte after the number).
module serial_number_encoder
    import serial_number_pkg::*;
#(
    parameter int unsigned NUMBER_BITS     = NUMBER_BITS_DEFAULT,
    parameter int unsigned NUMBER_BYTES    = NUMBER_BYTES_DEFAULT,
    parameter int unsigned BYTE_INDEX_BITS = BYTE_INDEX_BITS_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    serial_number_encoder_if.master enc
);

    localparam int unsigned TOTAL_BYTES = NUMBER_BYTES + CHECKSUM_BYTES;
    localparam int unsigned SHADOW_BITS = 8 * NUMBER_BYTES;
    localparam logic [BYTE_INDEX_BITS-1:0] LAST_INDEX = BYTE_INDEX_BITS'(TOTAL_BYTES - 1);
`ifdef SERIAL_NUMBER_CHECKSUM_EN
    localparam logic [BYTE_INDEX_BITS-1:0] CHECKSUM_INDEX = BYTE_INDEX_BITS'(NUMBER_BYTES);
`endif

    enc_state_t                   state_q, state_d;
    logic [NUMBER_BYTES-1:0][7:0] shadow_q, shadow_d;
    logic [BYTE_INDEX_BITS-1:0]   byte_index_q, byte_index_d;
    logic [7:0]                   tx_byte_q, tx_byte_d;
    logic                         tx_send_q, tx_send_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic [7:0]                   checksum_q, checksum_d;

    logic [NUMBER_BYTES-1:0][7:0] num_ext;
    logic [BYTE_INDEX_BITS-1:0]   next_index;
    logic                         handshake;

    // Next-state and registered-output logic for capture, byte stepping and done pulse.
    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        byte_index_d = byte_index_q;
        tx_byte_d    = tx_byte_q;
        tx_send_d    = tx_send_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        checksum_d   = checksum_q;

        // Sign extension happens once at capture so every byte select is a plain slice.
        num_ext    = SHADOW_BITS'(signed'(enc.num));
        next_index = byte_index_q + BYTE_INDEX_BITS'(1);
        handshake  = tx_send_q && enc.tx_ready;

        unique case (state_q)
            IDLE: begin
                if (enc.start) begin
                    shadow_d     = num_ext;
                    byte_index_d = '0;
                    tx_byte_d    = num_ext[0];
                    tx_send_d    = 1'b1;
                    busy_d       = 1'b1;
                    checksum_d   = '0;
                    state_d      = SEND;
                end
            end
            SEND: begin
                if (handshake) begin
                    checksum_d   = checksum_q ^ tx_byte_q;
                    byte_index_d = next_index;
                    if (byte_index_q == LAST_INDEX) begin
                        tx_send_d = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        state_d   = DONE;
                    end else begin
`ifdef SERIAL_NUMBER_CHECKSUM_EN
                        // The running XOR including the byte just accepted is the checksum byte.
                        tx_byte_d = (next_index == CHECKSUM_INDEX) ? checksum_d
                                                                   : shadow_q[next_index];
`else
                        tx_byte_d = shadow_q[next_index];
`endif
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                tx_send_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            shadow_q     <= '0;
            byte_index_q <= '0;
            tx_byte_q    <= '0;
            tx_send_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            checksum_q   <= '0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            byte_index_q <= byte_index_d;
            tx_byte_q    <= tx_byte_d;
            tx_send_q    <= tx_send_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            checksum_q   <= checksum_d;
        end
    end

    assign enc.tx_byte = tx_byte_q;
    assign enc.tx_send = tx_send_q;
    assign enc.busy    = busy_q;
    assign enc.done    = done_q;

endmodule

// File: tb/tb_serial_number_encoder.sv
// Self-checking bench for serial_number_encoder: queue-based reference model,
// per-cycle compare, plus literal expectations for the known byte patterns.
module tb_serial_number_encoder;

    localparam int unsigned NB  = 37;
    localparam int unsigned NBY = 5;
`ifdef SERIAL_NUMBER_CHECKSUM_EN
    localparam int unsigned CK = 1;
`else
    localparam int unsigned CK = 0;
`endif
    localparam int unsigned TOTAL = NBY + CK;

    typedef logic [7:0] bq_t[$];

    logic clk;
    logic reset;

    serial_number_encoder_if #(.NUMBER_BITS(NB)) enc_if ();

    serial_number_encoder #(
        .NUMBER_BITS    (NB),
        .NUMBER_BYTES   (NBY),
        .BYTE_INDEX_BITS(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .enc  (enc_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int done_seen = 0;

    // Model state: bytes still to be delivered, and whether the done pulse is due.
    bq_t  exp_q;
    logic m_done = 1'b0;
    bq_t  got;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Bytes that must appear on the link for value n: arithmetic shift of the signed value.
    function automatic bq_t bytes_of(input logic [NB-1:0] n);
        bq_t         q;
        longint      v;
        logic [7:0]  b;
        logic [7:0]  ck;
        v  = longint'($signed(n));
        ck = '0;
        for (int i = 0; i < NBY; i++) begin
            b = 8'(v >>> (8 * i));
            q.push_back(b);
            ck ^= b;
        end
        if (CK != 0) q.push_back(ck);
        return q;
    endfunction

    function automatic logic [NB-1:0] rand_num();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[NB-1:0];
    endfunction

    // Reference model advanced on every clock edge from the inputs seen at that edge.
    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_done = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (exp_q.size() != 0) begin
            if (enc_if.tx_ready) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) m_done = 1'b1;
            end
        end else if (enc_if.start) begin
            exp_q = bytes_of(enc_if.num);
        end
    end

    // Per-cycle compare of DUT outputs against the model; also logs accepted bytes.
    always @(negedge clk) begin
        check("tx_send", enc_if.tx_send, exp_q.size() != 0);
        check("busy", enc_if.busy, exp_q.size() != 0);
        check("done", enc_if.done, m_done);
        if (exp_q.size() != 0) check("tx_byte", enc_if.tx_byte, exp_q[0]);
        if (enc_if.tx_send && enc_if.tx_ready && !reset) got.push_back(enc_if.tx_byte);
        if (enc_if.done) done_seen++;
    end

    task automatic check_seq(input string name, input bq_t want);
        check({name, "_len"}, got.size(), want.size());
        for (int i = 0; i < want.size(); i++) begin
            if (i < got.size()) check(name, got[i], want[i]);
        end
    endtask

    task automatic wait_idle();
        int cnt;
        cnt = 0;
        while ((exp_q.size() != 0 || m_done) && cnt < 500) begin
            @(posedge clk); #2;
            cnt++;
        end
        check("idle_timeout", cnt < 500, 1'b1);
    endtask

    task automatic launch(input logic [NB-1:0] n);
        enc_if.num   = n;
        enc_if.start = 1'b1;
        @(posedge clk); #2;
        enc_if.start = 1'b0;
        enc_if.num   = rand_num();
    endtask

    task automatic run_random(input logic [NB-1:0] n, input int pct);
        int cnt;
        launch(n);
        cnt = 0;
        while ((exp_q.size() != 0 || m_done) && cnt < 400) begin
            enc_if.tx_ready = ($urandom_range(0, 99) < pct);
            @(posedge clk); #2;
            cnt++;
        end
        check("xfer_timeout", cnt < 400, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bq_t want;
        int  lat;
        int  d0;
        logic [NB-1:0] a;

        reset           = 1'b1;
        enc_if.start    = 1'b0;
        enc_if.num      = '0;
        enc_if.tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_tx_byte", enc_if.tx_byte, 8'h00);
        check("rst_tx_send", enc_if.tx_send, 1'b0);
        check("rst_busy", enc_if.busy, 1'b0);
        check("rst_done", enc_if.done, 1'b0);
        reset = 1'b0;
        @(posedge clk); #2;

        // Known value, ready tied high: byte order and done latency.
        got.delete();
        enc_if.tx_ready = 1'b1;
        launch(37'h0_1234_5678);
        lat = 1;
        while (!enc_if.done && lat < 30) begin
            @(posedge clk); #2;
            lat++;
        end
        check("done_latency", lat, NBY + 1 + CK);
        wait_idle();
        want = {8'h78, 8'h56, 8'h34, 8'h12, 8'h00};
        if (CK != 0) want.push_back(8'h08);
        check_seq("bytes_1234_5678", want);

        // All ones and sign-bit-only values.
        got.delete();
        launch('1);
        wait_idle();
        want = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        if (CK != 0) want.push_back(8'hFF);
        check_seq("bytes_minus1", want);

        got.delete();
        launch(37'h10_0000_0000);
        wait_idle();
        want = {8'h00, 8'h00, 8'h00, 8'h00, 8'hF0};
        if (CK != 0) want.push_back(8'hF0);
        check_seq("bytes_signbit", want);

        // Random values with random back-pressure.
        for (int i = 0; i < 20; i++) begin
            a = rand_num();
            got.delete();
            run_random(a, $urandom_range(20, 90));
            check_seq("bytes_random", bytes_of(a));
        end

        // Start pulsed mid-transfer with a different value is ignored.
        a = 37'h0A_BCDE_F012;
        got.delete();
        enc_if.tx_ready = 1'b0;
        launch(a);
        enc_if.num   = 37'h15_5555_5555;
        enc_if.start = 1'b1;
        @(posedge clk); #2;
        enc_if.start = 1'b0;
        check("busy_mid_start", enc_if.busy, 1'b1);
        begin
            int cnt;
            cnt = 0;
            while ((exp_q.size() != 0 || m_done) && cnt < 400) begin
                enc_if.tx_ready = ($urandom_range(0, 99) < 50);
                @(posedge clk); #2;
                cnt++;
            end
            check("xfer_timeout", cnt < 400, 1'b1);
        end
        check_seq("bytes_ignore_start", bytes_of(a));

        // Reset after the second byte is accepted aborts without done.
        got.delete();
        enc_if.tx_ready = 1'b1;
        d0 = done_seen;
        launch(37'h1F_0F0F_0F0F);
        @(posedge clk);
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        check("abort_tx_send", enc_if.tx_send, 1'b0);
        check("abort_busy", enc_if.busy, 1'b0);
        check("abort_bytes", got.size(), 2);
        repeat (8) @(posedge clk);
        #2;
        check("abort_no_done", done_seen, d0);
        got.delete();
        a = 37'h03_C3C3_C3C3;
        launch(a);
        wait_idle();
        check_seq("bytes_after_abort", bytes_of(a));

        // Start held high: ignored in DONE, accepted in the first IDLE cycle.
        got.delete();
        a = 37'h12_3456_789A;
        enc_if.num   = a;
        enc_if.start = 1'b1;
        lat = 0;
        @(posedge clk); #2;
        while (!enc_if.done && lat < 30) begin
            @(posedge clk); #2;
            lat++;
        end
        check("held_done_seen", enc_if.done, 1'b1);
        @(posedge clk); #2;
        check("held_busy_in_idle", enc_if.busy, 1'b0);
        @(posedge clk); #2;
        enc_if.start = 1'b0;
        check("held_restart_busy", enc_if.busy, 1'b1);
        wait_idle();
        want = bytes_of(a);
        for (int i = 0; i < TOTAL; i++) want.push_back(want[i]);
        check_seq("bytes_held_start", want);

        repeat (3) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
